pipe_select_mux: RTL and testbench

PIPE_SELECT_MUX -- requirements
Module: pipe_select_mux

---
 rtl/pipe_select_mux.sv | 152 +++++++++++++++
 tb/tb_pipe_select_mux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_select_mux.sv
// pipe_select_mux: selects one of NUM_IN data channels per accepted entry and
// buffers the result in a 2-entry skid buffer (EMPTY / ONE / TWO occupancy).
// All outputs come straight from flops. in_ready depends only on buffer
// occupancy, so there is no combinational path from out_ready to in_ready.
// Out-of-range selects fall back to DEFAULT_SEL and mark the entry with sel_err.
module pipe_select_mux #(
  parameter int DATA_W      = 32,
  parameter int NUM_IN      = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              err;
  } entry_t;

  localparam entry_t            ENTRY_ZERO = '0;
  localparam logic [SEL_W-1:0]  DEF_SEL    = SEL_W'(DEFAULT_SEL);

  // Resolve the effective channel and pick its data with an AND-OR mux, so an
  // out-of-range select can never index past the bus or leave a value held.
  function automatic entry_t build_entry(
    input logic [NUM_IN*DATA_W-1:0] data_bus,
    input logic [SEL_W-1:0]         sel_raw
  );
    entry_t           e;
    logic [SEL_W-1:0] eff;
    e = ENTRY_ZERO;
    if (32'(sel_raw) < 32'(NUM_IN)) begin
      eff   = sel_raw;
      e.err = 1'b0;
    end else begin
      eff   = DEF_SEL;
      e.err = 1'b1;
    end
    e.sel = eff;
    for (int k = 0; k < NUM_IN; k++) begin
      e.data = e.data | (data_bus[k*DATA_W +: DATA_W] & {DATA_W{eff == SEL_W'(k)}});
    end
    return e;
  endfunction

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   push_s;
  logic   pop_s;
  entry_t new_entry_s;

  // Next-state logic: occupancy transitions, head/tail movement, flush override.
  always_comb begin
    push_s      = in_valid & in_ready_q;
    pop_s       = out_valid_q & out_ready;
    new_entry_s = build_entry(in_data, sel);
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = ENTRY_ZERO;
      tail_d  = ENTRY_ZERO;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            head_d  = new_entry_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            state_d = ST_ONE;
            head_d  = new_entry_s;
          end else if (push_s) begin
            state_d = ST_TWO;
            tail_d  = new_entry_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
            head_d  = ENTRY_ZERO;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_d = ST_ONE;
            head_d  = tail_q;
            tail_d  = ENTRY_ZERO;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = ENTRY_ZERO;
          tail_d  = ENTRY_ZERO;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and output registers; reset empties the buffer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= ENTRY_ZERO;
      tail_q      <= ENTRY_ZERO;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q.data;
  assign out_sel   = head_q.sel;
  assign sel_err   = head_q.err;

endmodule

// File: tb/tb_pipe_select_mux.sv
// Testbench for pipe_select_mux: directed scenarios plus randomized traffic,
// checked against a queue-based FIFO model. Instance a uses defaults
// (NUM_IN=4); instance b uses NUM_IN=3, DEFAULT_SEL=1 for out-of-range selects.
module tb_pipe_select_mux;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4*DW-1:0] in_data;
  logic [1:0]    sel;
  logic          in_valid, flush, out_ready;

  logic          a_in_ready, a_out_valid, a_sel_err;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_out_sel;
  logic          b_in_ready, b_out_valid, b_sel_err;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_out_sel;

  pipe_select_mux #(.DATA_W(DW), .NUM_IN(4), .SEL_W(2), .DEFAULT_SEL(0)) u_a (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(a_in_ready), .flush(flush), .out_data(a_out_data), .out_sel(a_out_sel),
    .sel_err(a_sel_err), .out_valid(a_out_valid), .out_ready(out_ready));

  pipe_select_mux #(.DATA_W(DW), .NUM_IN(3), .SEL_W(2), .DEFAULT_SEL(1)) u_b (
    .clk(clk), .reset(reset), .in_data(in_data[3*DW-1:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(b_in_ready), .flush(flush), .out_data(b_out_data), .out_sel(b_out_sel),
    .sel_err(b_sel_err), .out_valid(b_out_valid), .out_ready(out_ready));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        err;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the select rule: in-range channel, else the default with error.
  function automatic ent_t mk(input int num_in, input int def_sel,
                              input logic [1:0] s, input logic [4*DW-1:0] d);
    ent_t e;
    int   ch;
    if (int'(s) < num_in) begin
      ch    = int'(s);
      e.err = 1'b0;
    end else begin
      ch    = def_sel;
      e.err = 1'b1;
    end
    e.sel  = 2'(ch);
    e.data = d[ch*DW +: DW];
    return e;
  endfunction

  task automatic model_edge();
    bit push_a, pop_a, push_b, pop_b;
    push_a = in_valid && (qa.size() < 2);
    pop_a  = out_ready && (qa.size() > 0);
    push_b = in_valid && (qb.size() < 2);
    pop_b  = out_ready && (qb.size() > 0);
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a)  void'(qa.pop_front());
      if (push_a) qa.push_back(mk(4, 0, sel, in_data));
      if (pop_b)  void'(qb.pop_front());
      if (push_b) qb.push_back(mk(3, 1, sel, in_data));
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".a_valid"}, 32'(a_out_valid), 32'(qa.size() > 0));
    chk({tag, ".a_ready"}, 32'(a_in_ready),  32'(qa.size() < 2));
    chk({tag, ".a_data"},  a_out_data,       (qa.size() > 0) ? qa[0].data : 32'h0);
    chk({tag, ".a_sel"},   32'(a_out_sel),   (qa.size() > 0) ? 32'(qa[0].sel) : 32'h0);
    chk({tag, ".a_err"},   32'(a_sel_err),   (qa.size() > 0) ? 32'(qa[0].err) : 32'h0);
    chk({tag, ".b_valid"}, 32'(b_out_valid), 32'(qb.size() > 0));
    chk({tag, ".b_ready"}, 32'(b_in_ready),  32'(qb.size() < 2));
    chk({tag, ".b_data"},  b_out_data,       (qb.size() > 0) ? qb[0].data : 32'h0);
    chk({tag, ".b_sel"},   32'(b_out_sel),   (qb.size() > 0) ? 32'(qb[0].sel) : 32'h0);
    chk({tag, ".b_err"},   32'(b_sel_err),   (qb.size() > 0) ? 32'(qb[0].err) : 32'h0);
  endtask

  task automatic cycle(input bit iv, input logic [1:0] s, input bit ordy, input bit fl,
                       input string tag);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    sel       = 2'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst.valid", 32'(a_out_valid), 32'h0);
    chk("rst.ready", 32'(a_in_ready),  32'h1);
    chk("rst.data",  a_out_data,       32'h0);
    chk("rst.sel",   32'(a_out_sel),   32'h0);
    chk("rst.err",   32'(a_sel_err),   32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic select, one cycle latency.
    cycle(1'b1, 2'd2, 1'b1, 1'b0, "basic");
    chk("basic.data", a_out_data, 32'h33);
    chk("basic.sel",  32'(a_out_sel), 32'h2);
    chk("basic.err",  32'(a_sel_err), 32'h0);
    chk("basic.valid", 32'(a_out_valid), 32'h1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "drain0");

    // Backpressure fills to TWO, then drains in order.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, "bp1");
    cycle(1'b1, 2'd3, 1'b0, 1'b0, "bp2");
    chk("bp.ready", 32'(a_in_ready), 32'h0);
    chk("bp.hold",  a_out_data, 32'h22);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, "bp3");
    chk("bp.stable", a_out_data, 32'h22);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "bp4");
    chk("bp.second", a_out_data, 32'h44);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "bp5");
    chk("bp.empty", 32'(a_out_valid), 32'h0);

    // Simultaneous push and pop in ONE.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, "pp1");
    cycle(1'b1, 2'd0, 1'b1, 1'b0, "pp2");
    chk("pp.data",  a_out_data, 32'h11);
    chk("pp.ready", 32'(a_in_ready), 32'h1);
    chk("pp.valid", 32'(a_out_valid), 32'h1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "pp3");
    chk("pp.empty", 32'(a_out_valid), 32'h0);

    // Out-of-range select on the 3-channel instance falls back to channel 1.
    cycle(1'b1, 2'd3, 1'b1, 1'b0, "oor");
    chk("oor.data", b_out_data, 32'h22);
    chk("oor.sel",  32'(b_out_sel), 32'h1);
    chk("oor.err",  32'(b_sel_err), 32'h1);
    chk("oor.a_data", a_out_data, 32'h44);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "drain1");

    // Flush from TWO with an offered entry.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, "fl1");
    cycle(1'b1, 2'd2, 1'b0, 1'b0, "fl2");
    cycle(1'b1, 2'd3, 1'b1, 1'b1, "fl3");
    chk("fl.valid", 32'(a_out_valid), 32'h0);
    chk("fl.data",  a_out_data, 32'h0);
    chk("fl.ready", 32'(a_in_ready), 32'h1);
    cycle(1'b0, 2'd0, 1'b1, 1'b0, "fl4");
    chk("fl.never", 32'(a_out_valid), 32'h0);
    // Flush from ONE beats a simultaneous push and pop.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, "fl5");
    cycle(1'b1, 2'd2, 1'b1, 1'b1, "fl6");
    chk("fl.one", 32'(a_out_valid), 32'h0);

    // Asynchronous reset between edges while holding one entry.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, "ar1");
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar.valid", 32'(a_out_valid), 32'h0);
    chk("ar.ready", 32'(a_in_ready), 32'h1);
    chk("ar.data",  a_out_data, 32'h0);
    qa.delete();
    qb.delete();
    #1;
    reset = 1'b0;
    cycle(1'b1, 2'd2, 1'b1, 1'b0, "ar2");
    chk("ar.after", a_out_data, 32'h33);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'(($urandom_range(0, 3)) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
